// File: rtl/instr_fetch_buffer.sv
// Fetch stage: takes one PC at a time, reads a word from instruction memory with a
// bounded wait, and queues {pc, instr, misalign, buserr} for decode; flush discards all.
module instr_fetch_buffer #(
  parameter int          DEPTH     = 2,
  parameter int          TIMEOUT   = 16,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pc_valid,
  input  logic [31:0] pc_addr,
  output logic        pc_ready,
  input  logic        flush,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        if_misalign,
  output logic        if_buserr
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int TW = $clog2(TIMEOUT) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_MIS  = 2'd2;
  localparam logic [1:0] S_DROP = 2'd3;

  // Handshakes: a transfer happens on a cycle where valid and ready are both high;
  // valid never depends on ready, and a flush cycle transfers nothing.

  logic [1:0]    state_q, state_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [31:0]   cur_pc_q, cur_pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [31:0]   pc_mem_q [DEPTH];
  logic [31:0]   pc_mem_d [DEPTH];
  logic [31:0]   instr_mem_q [DEPTH];
  logic [31:0]   instr_mem_d [DEPTH];
  logic [DEPTH-1:0] mis_mem_q, mis_mem_d, err_mem_q, err_mem_d;

  logic        accept, aligned, push, pop;
  logic [31:0] push_instr;
  logic        push_mis, push_err;

  always_comb begin
    aligned   = (pc_addr[1:0] == 2'b00);
    pc_ready  = (state_q == S_IDLE) && (count_q < CW'(DEPTH)) && !flush && !reset;
    accept    = pc_valid && pc_ready;
    imem_req  = accept && aligned;
    imem_addr = pc_addr;
    if_valid  = (count_q != '0) && !reset;
    pop       = if_valid && if_ready && !flush;
  end

  always_comb begin
    state_d    = state_q;
    tmo_d      = tmo_q;
    cur_pc_d   = cur_pc_q;
    push       = 1'b0;
    push_instr = NOP_INSTR;
    push_mis   = 1'b0;
    push_err   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d  = aligned ? S_WAIT : S_MIS;
          tmo_d    = '0;
          cur_pc_d = pc_addr;
        end
      end
      S_MIS: begin
        push     = 1'b1;
        push_mis = 1'b1;
        state_d  = S_IDLE;
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          push       = 1'b1;
          push_instr = imem_rdata;
          state_d    = S_IDLE;
          tmo_d      = '0;
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          // The late response still has to be swallowed before the next request.
          push     = 1'b1;
          push_err = 1'b1;
          state_d  = S_DROP;
          tmo_d    = '0;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_DROP: begin
        if (imem_rvalid) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (flush) begin
      tmo_d = '0;
      push  = 1'b0;
      case (state_q)
        S_WAIT:  state_d = imem_rvalid ? S_IDLE : S_DROP;
        S_DROP:  state_d = S_DROP;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    pc_mem_d    = pc_mem_q;
    instr_mem_d = instr_mem_q;
    mis_mem_d   = mis_mem_q;
    err_mem_d   = err_mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        pc_mem_d[wr_ptr_q]    = cur_pc_q;
        instr_mem_d[wr_ptr_q] = push_instr;
        mis_mem_d[wr_ptr_q]   = push_mis;
        err_mem_d[wr_ptr_q]   = push_err;
        wr_ptr_d              = wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_comb begin
    if_pc       = pc_mem_q[rd_ptr_q];
    if_instr    = instr_mem_q[rd_ptr_q];
    if_misalign = mis_mem_q[rd_ptr_q];
    if_buserr   = err_mem_q[rd_ptr_q];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      tmo_q     <= '0;
      cur_pc_q  <= '0;
      count_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      mis_mem_q <= '0;
      err_mem_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_q[i]    <= '0;
        instr_mem_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      tmo_q       <= tmo_d;
      cur_pc_q    <= cur_pc_d;
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      pc_mem_q    <= pc_mem_d;
      instr_mem_q <= instr_mem_d;
      mis_mem_q   <= mis_mem_d;
      err_mem_q   <= err_mem_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch_buffer.sv
// Random fetch/flush/reset traffic with a responding instruction memory, checked
// cycle by cycle against a queue-based model of the fetch stage.
module tb_instr_fetch_buffer;
  localparam int          DEPTH   = 2;
  localparam int          TIMEOUT = 16;
  localparam logic [31:0] NOP     = 32'h00000013;
  localparam int          W       = 66;
  localparam int          NCYC    = 4000;

  logic        clk = 1'b0;
  logic        reset;
  logic        pc_valid, pc_ready, flush;
  logic [31:0] pc_addr;
  logic        imem_req, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        if_valid, if_ready, if_misalign, if_buserr;
  logic [31:0] if_pc, if_instr;

  always #5 clk = ~clk;

  instr_fetch_buffer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .NOP_INSTR(NOP)) dut (
    .clk(clk), .reset(reset),
    .pc_valid(pc_valid), .pc_addr(pc_addr), .pc_ready(pc_ready),
    .flush(flush),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_instr(if_instr),
    .if_misalign(if_misalign), .if_buserr(if_buserr)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Expected decode queue: {pc, instr, misalign, buserr}
  logic [W-1:0] exp_q[$];
  bit          busy_mem, busy_mis, draining;
  int          waited;
  logic [31:0] pend_pc;
  bit          resp_pend;
  int          resp_cnt;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got=%0h expected=%0h", tag, $time, got, exp);
    end
  endtask

  function automatic int pick_delay();
    int r;
    r = $urandom_range(0, 9);
    if (r < 6) return $urandom_range(1, 3);
    if (r < 9) return $urandom_range(4, 10);
    return $urandom_range(15, 22);
  endfunction

  initial begin
    bit          rst, rv, stale, idle, exp_ready, acc, al, ev;
    logic [31:0] a;
    logic [W-1:0] h;

    reset = 1'b1; pc_valid = 1'b0; pc_addr = '0; flush = 1'b0;
    imem_rvalid = 1'b0; imem_rdata = '0; if_ready = 1'b0;
    busy_mem = 0; busy_mis = 0; draining = 0; waited = 0; pend_pc = '0;
    resp_pend = 0; resp_cnt = 0;

    // Reset cycles with a fetch offered: nothing may be accepted or presented.
    repeat (2) begin
      @(posedge clk); #1;
      pc_valid = 1'b1; pc_addr = 32'h40; if_ready = 1'b1; #1;
      check("rst_pc_ready", 64'(pc_ready), 64'd0);
      check("rst_if_valid", 64'(if_valid), 64'd0);
      check("rst_imem_req", 64'(imem_req), 64'd0);
    end
    @(posedge clk); #1;
    reset = 1'b0; pc_valid = 1'b0; #1;
    check("post_rst_pc_ready", 64'(pc_ready), 64'd1);
    check("post_rst_if_valid", 64'(if_valid), 64'd0);
    check("post_rst_if_pc", 64'(if_pc), 64'd0);
    check("post_rst_if_instr", 64'(if_instr), 64'd0);
    check("post_rst_flags", 64'({if_misalign, if_buserr}), 64'd0);

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(posedge clk); #1;
      rst = ($urandom_range(0, 199) == 0);
      rv  = 1'b0;
      if (resp_pend) begin
        resp_cnt--;
        if (resp_cnt == 0) begin rv = 1'b1; resp_pend = 0; end
      end
      imem_rvalid = rv;
      imem_rdata  = $urandom();
      // A response still owed to a fetch abandoned by reset: keep new fetches off the bus.
      stale = resp_pend && !busy_mem && !draining;
      flush = ($urandom_range(0, 24) == 0) && !(draining && rv);
      pc_valid = !stale && ($urandom_range(0, 9) < 7);
      a = 32'($urandom_range(0, 1023)) << 2;
      if ($urandom_range(0, 6) == 0) a[1:0] = 2'($urandom_range(1, 3));
      pc_addr  = a;
      if_ready = ($urandom_range(0, 9) < 6);
      reset    = rst;
      #1;

      idle      = !busy_mem && !busy_mis && !draining;
      exp_ready = !rst && idle && (exp_q.size() < DEPTH) && !flush;
      acc       = pc_valid && exp_ready;
      al        = (pc_addr[1:0] == 2'b00);
      ev        = !rst && (exp_q.size() != 0);
      check("pc_ready", 64'(pc_ready), 64'(exp_ready));
      check("imem_req", 64'(imem_req), 64'(acc && al));
      if (acc && al) check("imem_addr", 64'(imem_addr), 64'(pc_addr));
      check("if_valid", 64'(if_valid), 64'(ev));
      if (ev) begin
        h = exp_q[0];
        check("if_pc", 64'(if_pc), 64'(h[65:34]));
        check("if_instr", 64'(if_instr), 64'(h[33:2]));
        check("if_misalign", 64'(if_misalign), 64'(h[1]));
        check("if_buserr", 64'(if_buserr), 64'(h[0]));
      end

      if (rst) begin
        exp_q.delete();
        busy_mem = 0; busy_mis = 0; draining = 0;
      end else if (flush) begin
        exp_q.delete();
        if (busy_mem) begin
          busy_mem = 0;
          draining = !rv;
        end
        busy_mis = 0;
      end else begin
        if (ev && if_ready) void'(exp_q.pop_front());
        if (busy_mis) begin
          exp_q.push_back({pend_pc, NOP, 1'b1, 1'b0});
          busy_mis = 0;
        end else if (busy_mem) begin
          if (rv) begin
            exp_q.push_back({pend_pc, imem_rdata, 1'b0, 1'b0});
            busy_mem = 0;
          end else begin
            waited++;
            if (waited == TIMEOUT) begin
              exp_q.push_back({pend_pc, NOP, 1'b0, 1'b1});
              busy_mem = 0;
              draining = 1;
            end
          end
        end else if (draining) begin
          if (rv) draining = 0;
        end
        if (acc) begin
          pend_pc = pc_addr;
          if (al) begin
            busy_mem  = 1;
            waited    = 0;
            resp_pend = 1;
            resp_cnt  = pick_delay();
          end else begin
            busy_mis = 1;
          end
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
